// File: rtl/clk_div_pkg.sv
// Shared state encoding and default sizing for the programmable clock divider.
package clk_div_pkg;

    localparam int DEF_CNT_W   = 8;
    localparam int DEF_MIN_DIV = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

endpackage

// File: rtl/clk_div_core.sv
// Period counter and output stage: raw divided clock plus a 50%-duty version
// that stretches odd ratios by half an input cycle with a negedge flop.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] cur_div,
    input  logic             load,
    input  logic             run,
    output logic             boundary,
    output logic             clk_out,
    output logic             clk_out_50
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half_div;
    logic             q_pos;
    logic             q_neg;
    logic             odd;

    assign half_div = cur_div >> 1;
    assign boundary = run && (cnt == cur_div - CNT_W'(1));

    // The odd flag only changes where q_pos starts a new period, so a
    // ratio change can never mix even and odd shaping inside one period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            q_pos <= 1'b0;
            odd   <= 1'b0;
        end else begin
            if (!run || load || boundary) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            q_pos <= run && (cnt < half_div);
            if (!run) begin
                odd <= 1'b0;
            end else if (cnt == '0) begin
                odd <= cur_div[0];
            end
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            q_neg <= 1'b0;
        end else begin
            q_neg <= q_pos;
        end
    end

    assign clk_out    = q_pos;
    // Only combinational output: OR of two flops, both glitch-free.
    assign clk_out_50 = odd ? (q_pos | q_neg) : q_pos;

endmodule

// File: rtl/clk_div_ctrl.sv
// Configuration controller: valid/ready request intake, pending ratio/enable,
// and application of changes only at divided-clock period boundaries.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int MIN_DIV = DEF_MIN_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             cfg_en,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             clk_out,
    output logic             clk_out_50,
    output logic             div_active,
    output logic             busy,
    output logic [CNT_W-1:0] cur_div,
    output logic             cfg_err
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cur_div_nxt;
    logic [CNT_W-1:0] pend_div;
    logic [CNT_W-1:0] pend_div_nxt;
    logic             pend_en;
    logic             pend_en_nxt;
    logic             accept;
    logic             req_ok;
    logic             load;
    logic             boundary;

    assign accept = cfg_valid && cfg_ready;
    assign req_ok = (cfg_div >= CNT_W'(MIN_DIV));

    // Out-of-range requests are still accepted but leave all state untouched.
    always_comb begin
        state_nxt    = state;
        cur_div_nxt  = cur_div;
        pend_div_nxt = pend_div;
        pend_en_nxt  = pend_en;
        load         = 1'b0;
        case (state)
            IDLE: begin
                if (accept && req_ok && cfg_en) begin
                    cur_div_nxt = cfg_div;
                    load        = 1'b1;
                    state_nxt   = RUN;
                end
            end
            RUN: begin
                if (accept && req_ok) begin
                    pend_div_nxt = cfg_div;
                    pend_en_nxt  = cfg_en;
                    state_nxt    = PEND;
                end
            end
            PEND: begin
                if (boundary) begin
                    if (pend_en) begin
                        cur_div_nxt = pend_div;
                        load        = 1'b1;
                        state_nxt   = RUN;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cur_div    <= '0;
            pend_div   <= '0;
            pend_en    <= 1'b0;
            cfg_ready  <= 1'b0;
            busy       <= 1'b0;
            div_active <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cur_div    <= cur_div_nxt;
            pend_div   <= pend_div_nxt;
            pend_en    <= pend_en_nxt;
            cfg_ready  <= (state_nxt != PEND);
            busy       <= (state_nxt == PEND);
            div_active <= (state_nxt != IDLE);
            cfg_err    <= accept && !req_ok;
        end
    end

    clk_div_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .cur_div    (cur_div),
        .load       (load),
        .run        (state != IDLE),
        .boundary   (boundary),
        .clk_out    (clk_out),
        .clk_out_50 (clk_out_50)
    );

endmodule
